register_file_sb: RTL
=====================

# register_file_sb

Parametrised multi-read-port register file with same-cycle write bypass, optional hard-wired zero register, and a per-register busy scoreboard. It replaces the fixed 16x16, two-read-port register file in the processor decode stage. Issue logic reserves a destination register when an instruction is issued, and writeback clears the reservation. Each read port reports whether its operand is ready, so the decode stage can stall without a separate hazard unit.

## Interface
Parameters:
- WIDTH, 16, data bits per register
- ADDR_W, 4, register index bits; DEPTH = 2**ADDR_W
- NREAD, 2, number of read ports
- ZERO_REG, 1, when 1 register 0 always reads 0 and is never busy

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- rd_addr  in  NREAD*ADDR_W  read indices; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NREAD*WIDTH  read data, combinational; packed the same way as rd_addr
- rd_ready  out  NREAD  port i operand is valid this cycle
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback index
- wr_data  in  WIDTH  writeback data
- rsv_en  in  1  reserve a destination (mark busy)
- rsv_addr  in  ADDR_W  index to reserve
- flush  in  1  clear all busy bits (pipeline flush); register data unaffected
- busy  out  DEPTH  current scoreboard state, registered

## Operation
- Reset: all registers 0, busy = 0. While rst = 0, rd_data shows array contents, i.e. 0.
- Write: when wr_en = 1, mem[wr_addr] <= wr_data and busy[wr_addr] <= 0 at the clock edge.
- Reserve: when rsv_en = 1, busy[rsv_addr] <= 1.
- Same index, same cycle, wr_en and rsv_en both set: the reservation wins and the busy bit ends at 1. The data is still written. This covers back-to-back producers to one register.
- flush = 1 sets busy <= 0 for all registers. A reservation in the same cycle is discarded. A write in the same cycle still updates data.
- Read port i (combinational):
  - Zero register (ZERO_REG = 1 and rd_addr_i = 0): rd_data_i = 0, rd_ready_i = 1.
  - Bypass (wr_en = 1 and wr_addr = rd_addr_i): rd_data_i = wr_data, rd_ready_i = 1.
  - Otherwise: rd_data_i = mem[rd_addr_i], rd_ready_i = ~busy[rd_addr_i].
- A reservation does not affect rd_ready in its own cycle. It takes effect from the next cycle.
- ZERO_REG = 1:
  - Writes and reservations to index 0 are ignored.
  - busy[0] stays 0.
- Any NREAD ports may read the same index with no interference.

## Timing
- Read latency: 0 cycles (combinational from rd_addr, wr_*, and state).
- Write latency:
  - Visible via bypass in the same cycle.
  - Visible from the array from the next cycle.
- Reserve-to-not-ready: 1 cycle. Writeback-to-ready: 0 cycles via bypass, then held by the cleared busy bit.
- Reset is asynchronous on assertion. Deassertion must be synchronised externally to clk.
- Reset mid-operation: array and scoreboard clear immediately. In-flight writes are lost.
- There are no combinational paths from rsv_* or flush to any output.

## Structure
- Package regfile_pkg holds:
  - the default WIDTH, ADDR_W, and NREAD constants;
  - a function for the port-slice index.
- Sub-module rf_scoreboard holds the DEPTH busy flops and the rsv/wr/flush priority logic. It outputs busy.
- The top level holds the data array, read muxes, and bypass compare.

## Test plan
- Reset, then read all 16 indices on both ports -> rd_data = 0, rd_ready = 1, busy = 0.
- wr_en, wr_addr = 5, wr_data = 0xBEEF, with rd_addr0 = 5 in the same cycle -> rd_data0 = 0xBEEF, rd_ready0 = 1. Next cycle with wr_en = 0 -> still 0xBEEF.
- Reserve 3 at cycle t:
  - At t+1, read 3 -> rd_ready = 0, busy[3] = 1.
  - At t+3, write 3 = 0x1234 -> rd_ready = 1, data 0x1234 in that cycle.
  - At t+4, busy[3] = 0.
- Reserve 7 and write 7 = 0x00AA in the same cycle -> next cycle busy[7] = 1, rd_ready = 0, mem[7] = 0x00AA.
- ZERO_REG = 1: write 0 = 0xFFFF and reserve 0 -> read 0 gives 0, rd_ready = 1, busy[0] = 0.
- Reserve 2, 4, 9, then flush with a simultaneous reserve of 6 -> busy = 0, all rd_ready = 1. Assert rst mid-sequence -> all outputs back to reset values with no clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and packing helpers for the decode-stage register file.
// Ports are packed side by side in flat vectors.
package regfile_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_NREAD  = 2;

  // Returns the low bit of the field for `port` in a flat vector of `width`-bit fields.
  function automatic int sliceLo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy flags.
// A reservation beats a writeback clear, and a flush beats both.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  localparam int DEPTH   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              flush,
  output logic [DEPTH-1:0]  busy
);

  logic [DEPTH-1:0] busyNext;

  // NOTE: combinational blocks use blocking '=' with a full default first, so no latch is inferred.
  always_comb begin
    busyNext = busy;
    if (flush) begin
      busyNext = '0;
    end else begin
      if (wr_en)  busyNext[wr_addr]  = 1'b0;
      if (rsv_en) busyNext[rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) busyNext[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busyNext;
  end

endmodule

// File: rtl/register_file_sb.sv
// Multi-read-port register file with same-cycle write bypass and an optional zero register.
// It also holds a busy scoreboard, so each read port reports operand readiness.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NREAD    = DEF_NREAD,
  parameter int ZERO_REG = 1,
  localparam int DEPTH   = 2 ** ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*WIDTH-1:0]  rd_data,
  output logic [NREAD-1:0]        rd_ready,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rsv_en,
  input  logic [ADDR_W-1:0]       rsv_addr,
  input  logic                    flush,
  output logic [DEPTH-1:0]        busy
);

  logic [WIDTH-1:0] memArray [DEPTH];
  logic             wrAllowed;

  assign wrAllowed = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  // NOTE: the array is built from flops, not a RAM macro, so every entry can clear on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) memArray[r] <= '0;
    end else if (wrAllowed) begin
      memArray[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) uScoreboard (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .flush   (flush),
    .busy    (busy)
  );

  for (genvar p = 0; p < NREAD; p++) begin : gRead
    logic [ADDR_W-1:0] portAddr;
    logic [WIDTH-1:0]  portData;
    logic              portReady;

    assign portAddr = rd_addr[sliceLo(p, ADDR_W) +: ADDR_W];

    // The zero register outranks the bypass, so a write to index 0 never leaks through.
    always_comb begin
      portData  = memArray[portAddr];
      portReady = !busy[portAddr];
      if ((ZERO_REG != 0) && (portAddr == '0)) begin
        portData  = '0;
        portReady = 1'b1;
      end else if (wr_en && (wr_addr == portAddr)) begin
        portData  = wr_data;
        portReady = 1'b1;
      end
    end

    assign rd_data[sliceLo(p, WIDTH) +: WIDTH] = portData;
    assign rd_ready[p]                         = portReady;
  end

endmodule
